// File: rtl/fsb_adapter_arbiter.sv
// Round-robin N:1 request arbiter into an FSB adapter slave port, plus destination-decoded return fan-out.
// Optional per-requester grant counters are built when FSB_ADAPTER_ARBITER_STATS_EN is defined.
module fsb_adapter_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 80,
   parameter int DEST_MSB   = 79
) (
   input  logic                          clk_i,
   input  logic                          resetn_i,
   input  logic [NUM_REQ-1:0]            req_v_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_r_o,
   output logic                          adpt_slave_v_o,
   output logic [DATA_WIDTH-1:0]         adpt_slave_data_o,
   input  logic                          adpt_slave_r_i,
   input  logic                          adpt_master_v_i,
   input  logic [DATA_WIDTH-1:0]         adpt_master_data_i,
   output logic                          adpt_master_r_o,
   output logic [NUM_REQ-1:0]            resp_v_o,
   output logic [DATA_WIDTH-1:0]         resp_data_o,
   input  logic [NUM_REQ-1:0]            resp_r_i,
   output logic                          err_o,
   output logic [NUM_REQ*32-1:0]         grant_cnt_o
);

   localparam int   ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic                  state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                  err_q, err_d;

   logic                  load_s;
   logic                  grant_found_s;
   logic                  grant_v_s;
   logic [ID_W-1:0]       grant_idx_s;
   logic [ID_W:0]         scan_idx_s;
   logic [ID_W-1:0]       dest_s;
   logic                  dest_ok_s;

   assign load_s = (state_q == ST_EMPTY) || adpt_slave_r_i;

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {ID_W{1'b0}};
      scan_idx_s    = {(ID_W+1){1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_idx_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (scan_idx_s >= (ID_W+1)'(NUM_REQ)) begin
            scan_idx_s = scan_idx_s - (ID_W+1)'(NUM_REQ);
         end else begin
            scan_idx_s = scan_idx_s;
         end
         if (req_v_i[scan_idx_s[ID_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = scan_idx_s[ID_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
            grant_idx_s   = grant_idx_s;
         end
      end
   end

   // Ready is masked during reset so nothing is acknowledged that would be lost.
   assign grant_v_s = load_s && grant_found_s && resetn_i;

   always_comb begin
      req_r_o  = {NUM_REQ{1'b0}};
      state_d  = state_q;
      data_d   = data_q;
      rr_ptr_d = rr_ptr_q;
      if (grant_v_s) begin
         req_r_o  = NUM_REQ'(1'b1) << grant_idx_s;
         state_d  = ST_FULL;
         data_d   = req_data_i[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
         if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = {ID_W{1'b0}};
         end else begin
            rr_ptr_d = grant_idx_s + ID_W'(1'b1);
         end
      end else if (load_s) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   assign dest_s    = adpt_master_data_i[DEST_MSB -: ID_W];
   assign dest_ok_s = ({1'b0, dest_s} < (ID_W+1)'(NUM_REQ));

   // Bad destinations are swallowed: ready is forced high so the adapter never stalls on them.
   always_comb begin
      resp_v_o        = {NUM_REQ{1'b0}};
      adpt_master_r_o = 1'b1;
      err_d           = err_q;
      if (dest_ok_s) begin
         resp_v_o        = {{(NUM_REQ-1){1'b0}}, adpt_master_v_i} << dest_s;
         adpt_master_r_o = resp_r_i[dest_s];
      end else if (adpt_master_v_i) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q  <= ST_EMPTY;
         data_q   <= {DATA_WIDTH{1'b0}};
         rr_ptr_q <= {ID_W{1'b0}};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   assign adpt_slave_v_o    = (state_q == ST_FULL);
   assign adpt_slave_data_o = data_q;
   assign resp_data_o       = adpt_master_data_i;
   assign err_o             = err_q;

`ifdef FSB_ADAPTER_ARBITER_STATS_EN
   logic [NUM_REQ-1:0][31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (grant_v_s && (cnt_q[grant_idx_s] != 32'hFFFF_FFFF)) begin
         cnt_d[grant_idx_s] = cnt_q[grant_idx_s] + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         cnt_q <= {(NUM_REQ*32){1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt_o = cnt_q;
`else
   assign grant_cnt_o = {(NUM_REQ*32){1'b0}};
`endif

endmodule

// File: tb/tb_fsb_adapter_arbiter.sv
// Randomized and directed checks of fsb_adapter_arbiter against a queue-based reference model.
module tb_fsb_adapter_arbiter;

   localparam int N  = 4;
   localparam int N3 = 3;
   localparam int DW = 80;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              resetn;
   logic [N-1:0]      req_v, req_r, resp_v, resp_r;
   logic [N*DW-1:0]   req_data;
   logic              slave_v, slave_r, m_v, m_r, err;
   logic [DW-1:0]     slave_data, m_data, resp_data;
   logic [N*32-1:0]   gcnt;

   logic [N3-1:0]     req3_v, req3_r, resp3_v, resp3_r;
   logic [N3*DW-1:0]  req3_data;
   logic              slave3_v, m3_v, m3_r, err3;
   logic [DW-1:0]     slave3_data, m3_data, resp3_data;
   logic [N3*32-1:0]  gcnt3;

   fsb_adapter_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .DEST_MSB(79)) u_dut (
      .clk_i(clk), .resetn_i(resetn), .req_v_i(req_v), .req_data_i(req_data), .req_r_o(req_r),
      .adpt_slave_v_o(slave_v), .adpt_slave_data_o(slave_data), .adpt_slave_r_i(slave_r),
      .adpt_master_v_i(m_v), .adpt_master_data_i(m_data), .adpt_master_r_o(m_r),
      .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_r_i(resp_r), .err_o(err), .grant_cnt_o(gcnt));

   fsb_adapter_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW), .DEST_MSB(79)) u_dut3 (
      .clk_i(clk), .resetn_i(resetn), .req_v_i(req3_v), .req_data_i(req3_data), .req_r_o(req3_r),
      .adpt_slave_v_o(slave3_v), .adpt_slave_data_o(slave3_data), .adpt_slave_r_i(1'b0),
      .adpt_master_v_i(m3_v), .adpt_master_data_i(m3_data), .adpt_master_r_o(m3_r),
      .resp_v_o(resp3_v), .resp_data_o(resp3_data), .resp_r_i(resp3_r), .err_o(err3), .grant_cnt_o(gcnt3));

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] sb_q[$];
   int            ptr_m;
   int            cnt_m[N];
   int            exp_grant;
   int            order[5] = '{0, 1, 2, 3, 0};

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_cnt();
      logic [127:0] r;
      r = '0;
`ifdef FSB_ADAPTER_ARBITER_STATS_EN
      for (int k = 0; k < N; k++) r[32*k +: 32] = 32'(cnt_m[k]);
`endif
      return r;
   endfunction

   task automatic model_clear();
      sb_q.delete();
      ptr_m = 0;
      for (int k = 0; k < N; k++) cnt_m[k] = 0;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic rand_req_data();
      for (int k = 0; k < N; k++) req_data[k*DW +: DW] = DW'({$urandom(), $urandom(), $urandom()});
   endtask

   // Checks all outputs against the model for the inputs already driven, then advances one edge.
   task automatic step();
      logic [N-1:0] exp_r;
      logic [N-1:0] exp_resp;
      int d;
      int k;
      #1;
      exp_grant = -1;
      if (sb_q.size() == 0 || slave_r) begin
         for (int j = 0; j < N; j++) begin
            k = (ptr_m + j) % N;
            if (exp_grant < 0 && req_v[k]) exp_grant = k;
         end
      end
      exp_r = '0;
      if (exp_grant >= 0) exp_r[exp_grant] = 1'b1;
      check_val("slave_v", 128'(slave_v), 128'(sb_q.size() == 1));
      if (sb_q.size() != 0) check_val("slave_data", 128'(slave_data), 128'(sb_q[0]));
      check_val("req_r", 128'(req_r), 128'(exp_r));
      d = int'(m_data[79:78]);
      exp_resp = '0;
      exp_resp[d] = m_v;
      check_val("resp_v", 128'(resp_v), 128'(exp_resp));
      check_val("master_r", 128'(m_r), 128'(resp_r[d]));
      check_val("resp_data", 128'(resp_data), 128'(m_data));
      check_val("err", 128'(err), 128'(1'b0));
      check_val("grant_cnt", 128'(gcnt), exp_cnt());
      @(posedge clk);
      if (sb_q.size() != 0 && slave_r) void'(sb_q.pop_front());
      if (exp_grant >= 0) begin
         sb_q.push_back(req_data[exp_grant*DW +: DW]);
         ptr_m = (exp_grant + 1) % N;
         cnt_m[exp_grant]++;
      end
   endtask

   initial begin
      logic [127:0] e;
      resetn = 1'b0; req_v = 4'hF; slave_r = 1'b0; m_v = 1'b0; m_data = '0; resp_r = '0;
      req3_v = '0; req3_data = '0; m3_v = 1'b0; m3_data = '0; resp3_r = '0;
      rand_req_data();
      model_clear();
      #12;
      check_val("rst_slave_v", 128'(slave_v), 128'(1'b0));
      check_val("rst_req_r", 128'(req_r), 128'(4'b0000));
      check_val("rst_err", 128'(err), 128'(1'b0));
      check_val("rst_cnt", 128'(gcnt), 128'(0));
      @(negedge clk);
      resetn = 1'b1;

      // All requesters active, adapter always ready: strict rotation.
      req_v = 4'hF; slave_r = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         rand_req_data();
         #1;
         check_val("rr_order", 128'(req_r), 128'(4'b0001 << order[c]));
         if (c > 0) check_val("rr_v_cont", 128'(slave_v), 128'(1'b1));
         step();
      end

      // Backpressure holds the packet from requester 2.
      @(negedge clk);
      apply_reset();
      req_v = 4'b0100; slave_r = 1'b0; rand_req_data();
      req_data[2*DW +: DW] = 80'h1234;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rand_req_data();
         #1;
         check_val("hold_data", 128'(slave_data), 128'(80'h1234));
         check_val("hold_req_r", 128'(req_r), 128'(4'b0000));
         step();
      end
      @(negedge clk);
      slave_r = 1'b1; req_v = 4'b0000;
      step();
      @(negedge clk);
      #1;
      check_val("drained", 128'(slave_v), 128'(1'b0));

      // Return path, valid destination.
      m_v = 1'b1; m_data = {2'b01, 78'(DW'({$urandom(), $urandom(), $urandom()}))}; resp_r = 4'b0010;
      #1;
      check_val("ret_v", 128'(resp_v), 128'(4'b0010));
      check_val("ret_r1", 128'(m_r), 128'(1'b1));
      resp_r = 4'b0000;
      #1;
      check_val("ret_r0", 128'(m_r), 128'(1'b0));
      m_v = 1'b0;

      // Reset suppresses the error flag on a bad destination.
      @(negedge clk);
      m3_v = 1'b1; m3_data = {2'b11, 78'h0}; resp3_r = 3'b111;
      resetn = 1'b0;
      #1;
      check_val("rst3_v", 128'(resp3_v), 128'(3'b000));
      check_val("rst3_r", 128'(m3_r), 128'(1'b1));
      @(posedge clk);
      #1;
      check_val("rst3_err", 128'(err3), 128'(1'b0));
      @(negedge clk);
      m3_v = 1'b0; resetn = 1'b1; model_clear();

      // NUM_REQ=3: destination 1 routes, destination 3 is dropped and flagged.
      @(negedge clk);
      m3_v = 1'b1; m3_data = {2'b01, 78'h5}; resp3_r = 3'b010;
      #1;
      check_val("d3_v", 128'(resp3_v), 128'(3'b010));
      check_val("d3_r", 128'(m3_r), 128'(1'b1));
      @(negedge clk);
      m3_data = {2'b11, 78'h7}; resp3_r = 3'b000;
      #1;
      check_val("bad_v", 128'(resp3_v), 128'(3'b000));
      check_val("bad_r", 128'(m3_r), 128'(1'b1));
      check_val("bad_err_pre", 128'(err3), 128'(1'b0));
      @(posedge clk);
      #1;
      check_val("bad_err", 128'(err3), 128'(1'b1));
      m3_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("bad_err_hold", 128'(err3), 128'(1'b1));

      // Asynchronous reset while holding a packet.
      @(negedge clk);
      apply_reset();
      req_v = 4'b1000; slave_r = 1'b0; rand_req_data();
      step();
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check_val("async_v", 128'(slave_v), 128'(1'b0));
      check_val("async_req_r", 128'(req_r), 128'(4'b0000));
      check_val("async_err3", 128'(err3), 128'(1'b0));
      model_clear();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1; req_v = 4'b1001; slave_r = 1'b1;
      #1;
      check_val("post_rst_grant", 128'(req_r), 128'(4'b0001));
      step();

      // Ten grants to requester 1.
      @(negedge clk);
      apply_reset();
      req_v = 4'b0010; slave_r = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         rand_req_data();
         step();
      end
      @(negedge clk);
      req_v = 4'b0000;
      #1;
      e = '0;
`ifdef FSB_ADAPTER_ARBITER_STATS_EN
      e[63:32] = 32'd10;
`endif
      check_val("cnt10", 128'(gcnt), e);
      step();

      // Random traffic on both paths at once.
      @(negedge clk);
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         if (c > 0) @(negedge clk);
         req_v   = 4'($urandom());
         rand_req_data();
         slave_r = ($urandom_range(0, 9) < 6);
         m_v     = 1'($urandom());
         m_data  = DW'({$urandom(), $urandom(), $urandom()});
         resp_r  = 4'($urandom());
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fsb_adapter_arbiter.md
FSB_ADAPTER_ARBITER -- requirements
Module: fsb_adapter_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of CL requesters (2..16).
REQ-002 Parameter DATA_WIDTH, default 80, is the FSB packet width.
REQ-003 Parameter DEST_MSB, default 79, is the top bit of the destination-ID field; the field is ID_W = clog2(NUM_REQ) bits wide, ending at DEST_MSB.
REQ-004 clk_i  input  1  sole clock; all logic rising-edge.
REQ-005 resetn_i  input  1  reset, asynchronous and active-low.
REQ-006 req_v_i  input  NUM_REQ  per-requester packet valid toward host.
REQ-007 req_data_i  input  NUM_REQ*DATA_WIDTH  per-requester packet, requester k in slice k.
REQ-008 req_r_o  output  NUM_REQ  per-requester ready; one-hot or zero.
REQ-009 adpt_slave_v_o  output  1  packet valid into adapter slave port.
REQ-010 adpt_slave_data_o  output  DATA_WIDTH  packet into adapter.
REQ-011 adpt_slave_r_i  input  1  adapter ready.
REQ-012 adpt_master_v_i  input  1  host-to-CL packet valid from adapter.
REQ-013 adpt_master_data_i  input  DATA_WIDTH  host-to-CL packet.
REQ-014 adpt_master_r_o  output  1  ready back to adapter.
REQ-015 resp_v_o  output  NUM_REQ  per-destination valid.
REQ-016 resp_data_o  output  DATA_WIDTH  shared broadcast of adpt_master_data_i.
REQ-017 resp_r_i  input  NUM_REQ  per-destination ready.
REQ-018 err_o  output  1  sticky bad-destination flag.
REQ-019 grant_cnt_o  output  NUM_REQ*32  per-requester grant counts (see Configuration).

Function
REQ-020 Request path SHALL hold one output register (states EMPTY, FULL); adpt_slave_v_o = FULL.
REQ-021 Register SHALL load when EMPTY, or FULL with adpt_slave_r_i=1 (same-cycle drain and refill, no bubble).
REQ-022 When loadable, grant SHALL go to first asserted req_v_i at or after rr_ptr, wrapping NUM_REQ-1 to 0; req_r_o SHALL be one-hot at granted index, else zero.
REQ-023 Accept latency: req handshake in cycle N -> adpt_slave_v_o with that data in cycle N+1.
REQ-024 On each grant rr_ptr SHALL become grant+1 mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-025 While FULL and adpt_slave_r_i=0, adpt_slave_data_o SHALL hold stable and req_r_o SHALL be zero.
REQ-026 FULL with adpt_slave_r_i=1 and no requests SHALL go EMPTY.
REQ-027 Return path SHALL be combinational: d = adpt_master_data_i[DEST_MSB -: ID_W]; resp_v_o[d] = adpt_master_v_i, others 0; adpt_master_r_o = resp_r_i[d].
REQ-028 d >= NUM_REQ SHALL drop the packet: resp_v_o all 0, adpt_master_r_o=1, err_o set on handshake.
REQ-029 err_o SHALL stay set until reset.
REQ-030 Request and return paths SHALL be independent; simultaneous activity on both SHALL not stall either.

Reset
REQ-031 resetn_i low SHALL immediately force: state EMPTY, adpt_slave_v_o=0, req_r_o=0, rr_ptr=0, err_o=0, counters 0, regardless of clock.
REQ-032 Reset mid-transfer SHALL discard the held packet; first grant after deassertion starts from index 0.
REQ-033 resp_v_o/adpt_master_r_o follow inputs combinationally during reset except err_o update is suppressed.

Configuration
REQ-034 Macro FSB_ADAPTER_ARBITER_STATS_EN defined: per-requester 32-bit counters increment on each grant to that requester, saturating at 32'hFFFF_FFFF.
REQ-035 Macro undefined: no counter flops; grant_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-036 All 4 req_v_i held high, adpt_slave_r_i=1 -> grant order 0,1,2,3,0 on consecutive cycles, adpt_slave_v_o continuously 1.
REQ-037 Requester 2 sends 80'h1234 with adpt_slave_r_i=0 for 5 cycles -> adpt_slave_data_o=80'h1234 stable, req_r_o=0 throughout, released on cycle r rises.
REQ-038 Host packet with dest=1, resp_r_i=4'b0010 -> resp_v_o=4'b0010, adpt_master_r_o=1; with resp_r_i=0 -> adpt_master_r_o=0.
REQ-039 NUM_REQ=3, host packet dest=3 -> resp_v_o=0, adpt_master_r_o=1, err_o=1 next cycle and held.
REQ-040 Assert resetn_i low while FULL -> adpt_slave_v_o=0 without clock edge; after release only req 3 and 0 active -> grant 0 first.
REQ-041 STATS_EN, 10 grants to requester 1 -> grant_cnt_o slice 1 = 10, others 0; macro off -> all 0.
